// File: rtl/serial_stream_tx.sv
// serial_stream_tx: parallel-to-serial bit-stream transmitter.
// Takes a WIDTH-bit word through a valid/ready handshake, shifts it out
// LSB-first one bit per clock on a registered output, then holds an idle
// gap before accepting the next word. It also counts the 1->0 falls that
// occur on x_out while the word is being sent.
module serial_stream_tx #(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       load_in,
    output logic                       ready_out,
    output logic                       x_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [$clog2(WIDTH+1)-1:0] fall_cnt_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] BITS_ALL = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  shift_reg, shift_next;
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
    logic [CW-1:0]     fall_reg, fall_next;
    logic              x_reg, x_next;
    logic              done_reg, done_next;

    // State register; the low-going reset forces IDLE at once, no clock needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: shifter, counters and the registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            fall_reg    <= '0;
            x_reg       <= IDLE_LEVEL;
            done_reg    <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            fall_reg    <= fall_next;
            x_reg       <= x_next;
            done_reg    <= done_next;
        end
    end

    // Next-state and next-output logic for the IDLE -> SHIFT -> GAP sequence.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        fall_next    = fall_reg;
        x_next       = x_reg;
        done_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                x_next = IDLE_LEVEL;
                if (load_in) begin
                    // bit_cnt counts bits already placed on x_out
                    shift_next   = data_in;
                    x_next       = data_in[0];
                    bit_cnt_next = CW'(1);
                    fall_next    = (x_reg && !data_in[0]) ? CW'(1) : '0;
                    state_next   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bit_cnt_reg == BITS_ALL) begin
                    // Last bit has been on the line for one cycle; the drop to
                    // the idle level here is deliberately not counted as a fall.
                    x_next       = IDLE_LEVEL;
                    done_next    = 1'b1;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    state_next   = (GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    x_next       = shift_reg[1];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + CW'(1);
                    if (x_reg && !shift_reg[1] && (fall_reg != {CW{1'b1}})) begin
                        fall_next = fall_reg + CW'(1);
                    end
                end
            end

            S_GAP: begin
                x_next = IDLE_LEVEL;
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end

            default: begin
                x_next     = IDLE_LEVEL;
                state_next = S_IDLE;
            end
        endcase
    end

    assign ready_out    = (state_reg == S_IDLE);
    assign busy_out     = (state_reg == S_SHIFT) || (state_reg == S_GAP);
    assign x_out        = x_reg;
    assign done_out     = done_reg;
    assign fall_cnt_out = fall_reg;

endmodule
